if_id_fetch_buffer: RTL and testbench
=====================================

Name: if_id_fetch_buffer

Overview:
Sits between the instruction fetch stage and the ID stage.
- Replaces a plain IF/ID register with a small FIFO, so instruction-memory responses are absorbed while decode is stalled.
- Presents the head entry to decode as pc_d / instruction_d with a valid qualifier.
- Supports hazard-unit stall and branch/jump flush; flushed slots present a NOP bubble downstream.

Parameters:
- WIDTH, 32: PC and instruction width.
- DEPTH, 2: number of buffer entries; power of two, at least 2.
- NOP_INSTR, 32'h0000_0013: bubble instruction (addi x0,x0,0) driven when no valid entry is present.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pc_f  input  WIDTH  PC of the fetched instruction
- instruction_f  input  WIDTH  fetched instruction word
- fetch_valid  input  1  pc_f/instruction_f valid this cycle
- fetch_ready  output  1  buffer accepts a push this cycle
- stall_d  input  1  hazard unit holds the ID stage
- flush  input  1  taken branch/jump in EX; discard all buffered entries
- pc_d  output  WIDTH  PC of the head entry
- pc_plus4_d  output  WIDTH  pc_d + 4, modulo 2^WIDTH
- instruction_d  output  WIDTH  head instruction, or NOP_INSTR when not valid
- valid_d  output  1  head entry valid
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset low, asynchronous):
  - Pointers and count clear to 0; storage contents are don't-care.
  - Outputs: valid_d=0, instruction_d=NOP_INSTR, pc_d=0, pc_plus4_d=4, fetch_ready=1.
- Push: fetch_valid && fetch_ready at a rising edge writes {pc_f, instruction_f} at the tail. Tail wraps modulo DEPTH.
- Pop: valid_d && !stall_d at a rising edge retires the head. Head wraps modulo DEPTH.
- fetch_ready = (count < DEPTH).
  - It depends only on registered state, with no combinational path from stall_d.
  - It is therefore 0 when full, even if a pop happens in the same cycle.
- Latency: an entry pushed at edge N is visible on pc_d/instruction_d/valid_d after edge N. The buffer has a one-cycle minimum latency and no flow-through.
- Outputs are driven combinationally from registered storage and head pointer. When valid_d=0, instruction_d=NOP_INSTR, and pc_d holds its last value (0 after reset).
- Simultaneous push and pop (count between 1 and DEPTH-1, or count=1): count is unchanged and both pointers advance.
- Push into an empty buffer: valid_d rises after that edge.
- Stall on an empty buffer: no effect. Stall with valid_d=1 holds all outputs stable.
- Flush has the highest priority:
  - At the edge, head, tail and count clear to 0.
  - Any same-cycle push and pop are both discarded.
  - After the edge: valid_d=0, instruction_d=NOP_INSTR, fetch_ready=1.
- Flush together with stall: flush wins.
- Flush with an empty buffer: harmless no-op.
- Reset asserted mid-operation: all state clears immediately, independent of clk.
- Count never exceeds DEPTH and never underflows; pop is gated by valid_d.

Optional Feature:
Macro FETCH_BUF_STATS_EN.
- When defined, the block adds two output ports, each reset to 0 and saturating at all-ones:
  - stall_cycles (32 bits): increments each cycle with valid_d && stall_d.
  - flushed_entries (16 bits): at each flush edge, adds the count value present before the flush.
- When not defined, the ports and counters do not exist. Functional behaviour is identical either way.

Decomposition:
- Package riscv_pipe_pkg holds:
  - XLEN=32 and NOP_INSTR=32'h0000_0013.
  - A typedef for the fetch packet {pc, instruction}.
- One sub-module is natural: fetch_buf_ctrl.
  - Owns head, tail and count, plus push/pop/flush arbitration.
  - Parameterised by DEPTH.
- The top level holds the storage array, the output muxing and the optional stats counters.

Test Plan:
1. Reset then release; push pc_f=0x100, instruction_f=0x00500093 with stall_d=0 -> next cycle valid_d=1, pc_d=0x100, pc_plus4_d=0x104, instruction_d=0x00500093; following cycle valid_d=0, instruction_d=0x00000013.
2. Hold stall_d=1 and push 0x200, 0x204, 0x208 -> count reaches 2, fetch_ready=0, third push refused; pc_d stays 0x200. Release stall -> outputs 0x200 then 0x204; 0x208 is re-presented by fetch and accepted.
3. Continuous push/pop (stall_d=0, fetch_valid=1) for 10 cycles from PC 0x0 -> pc_d sequence 0x0,0x4,...,0x24 with no bubbles; count stays 1; pointers wrap cleanly.
4. Buffer full (0x300, 0x304); assert flush, stall_d and fetch_valid in the same cycle -> next cycle count=0, valid_d=0, instruction_d=NOP, fetch_ready=1. With FETCH_BUF_STATS_EN, flushed_entries += 2.
5. Pull reset low mid-stream, between clock edges, with count=2 -> outputs reach reset values immediately, before the next clk edge.
6. pc_f=0xFFFFFFFC -> pc_plus4_d=0x00000000, wrap-around is correct.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RISC-V front end.
//   XLEN        : architectural register / PC width
//   NOP_INSTR   : bubble instruction (addi x0,x0,0)
//   fetch_pkt_t : one fetched instruction together with its PC
package riscv_pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_buf_ctrl.sv
// Pointer / occupancy control for the IF/ID fetch buffer.
// It owns head, tail and count. It also arbitrates push, pop and flush;
// flush beats everything else.
// Ports:
//   clk, reset          : clock, async active-low reset
//   fetch_valid         : fetch offers an entry
//   stall_d             : decode is held, so the head is not retired
//   flush               : drop all entries; same-cycle push/pop ignored
//   push, pop           : qualified write / retire strobes for this cycle
//   head, tail          : read / write slot indices
//   count               : occupancy, 0..DEPTH
//   valid               : buffer is not empty
//   ready               : buffer is not full (registered state only)
module fetch_buf_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_valid,
    input  logic          stall_d,
    input  logic          flush,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] head,
    output logic [AW-1:0] tail,
    output logic [AW:0]   count,
    output logic          valid,
    output logic          ready
);

    // ready comes only from count, so stall_d has no path to fetch_ready.
    // A full buffer therefore refuses a push even in a cycle where it pops.
    always_comb begin
        valid = (count != '0);
        ready = (count < (AW+1)'(DEPTH));
        push  = fetch_valid && ready && !flush;
        pop   = valid && !stall_d && !flush;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_fetch_buffer.sv
// IF/ID fetch buffer: a small FIFO that replaces the plain IF/ID register.
// Instruction-memory responses are absorbed while decode is stalled.
// The head entry drives decode with no flow-through, so there is one cycle
// of latency. When the buffer is empty, decode sees NOP_INSTR and the last
// presented PC.
// Optional: define FETCH_BUF_STATS_EN to add the stall_cycles and
// flushed_entries counters. Both saturate.
// Ports:
//   clk, reset                  : clock, async active-low reset
//   pc_f, instruction_f         : fetched PC / instruction
//   fetch_valid / fetch_ready   : push handshake
//   stall_d                     : hazard-unit hold of ID
//   flush                       : taken branch/jump, drop buffered entries
//   pc_d, pc_plus4_d            : head PC and head PC + 4
//   instruction_d, valid_d      : head instruction (NOP if empty), valid flag
//   count                       : occupancy
//   stall_cycles                : [stats] cycles with valid_d && stall_d
//   flushed_entries             : [stats] total entries dropped by flush
module if_id_fetch_buffer
    import riscv_pipe_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(riscv_pipe_pkg::NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         pc_f,
    input  logic [WIDTH-1:0]         instruction_f,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic                     stall_d,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pc_d,
    output logic [WIDTH-1:0]         pc_plus4_d,
    output logic [WIDTH-1:0]         instruction_d,
    output logic                     valid_d,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_BUF_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [15:0]              flushed_entries
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instruction;
    } pkt_t;

    logic          push, pop;
    logic [AW-1:0] head, tail;
    pkt_t          mem [DEPTH];
    pkt_t          head_pkt;
    logic [WIDTH-1:0] pc_hold;

    fetch_buf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .stall_d     (stall_d),
        .flush       (flush),
        .push        (push),
        .pop         (pop),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .valid       (valid_d),
        .ready       (fetch_ready)
    );

    // Storage is not reset; entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{pc: pc_f, instruction: instruction_f};
    end

    // Track the PC being presented, so pc_d keeps its last value after the
    // buffer drains or is flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       pc_hold <= '0;
        else if (valid_d) pc_hold <= head_pkt.pc;
    end

    always_comb begin
        head_pkt      = mem[head];
        pc_d          = valid_d ? head_pkt.pc : pc_hold;
        instruction_d = valid_d ? head_pkt.instruction : NOP_INSTR;
        pc_plus4_d    = pc_d + WIDTH'(4);
    end

`ifdef FETCH_BUF_STATS_EN
    logic [16:0] flush_sum;
    assign flush_sum = {1'b0, flushed_entries} + 17'(count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles    <= '0;
            flushed_entries <= '0;
        end else begin
            if (valid_d && stall_d && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (flush)
                flushed_entries <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
module tb_if_id_fetch_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] pc_f, instruction_f;
    logic             fetch_valid, fetch_ready;
    logic             stall_d, flush;
    logic [WIDTH-1:0] pc_d, pc_plus4_d, instruction_d;
    logic             valid_d;
    logic [$clog2(DEPTH):0] count;
`ifdef FETCH_BUF_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flushed_entries;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_id_fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_f          (pc_f),
        .instruction_f (instruction_f),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .stall_d       (stall_d),
        .flush         (flush),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d),
        .instruction_d (instruction_d),
        .valid_d       (valid_d),
        .count         (count)
`ifdef FETCH_BUF_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flushed_entries (flushed_entries)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, 64'(valid_d), 64'd0);
        chk({tag, ".instr"}, 64'(instruction_d), 64'(NOP));
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".ready"}, 64'(fetch_ready), 64'd1);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        pc_f = pc; instruction_f = ins; fetch_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b0; pc_f = '0; instruction_f = '0;
        fetch_valid = 1'b0; stall_d = 1'b0; flush = 1'b0;
        #12;
        // Values held during reset.
        chk_empty("rst");
        chk("rst.pc", 64'(pc_d), 64'd0);
        chk("rst.pc4", 64'(pc_plus4_d), 64'd4);
        reset = 1'b1;
        step();

        // Test 1: single push, then pop to a bubble.
        push(32'h100, 32'h0050_0093);
        step();
        chk("t1.valid", 64'(valid_d), 64'd1);
        chk("t1.pc", 64'(pc_d), 64'h100);
        chk("t1.pc4", 64'(pc_plus4_d), 64'h104);
        chk("t1.instr", 64'(instruction_d), 64'h0050_0093);
        fetch_valid = 1'b0;
        step();
        chk_empty("t1b");
        chk("t1b.pc_hold", 64'(pc_d), 64'h100);

        // Stall on an empty buffer does nothing.
        stall_d = 1'b1;
        step();
        chk_empty("stall_empty");

        // Test 2: fill while stalled; third push refused.
        push(32'h200, 32'h1);
        step();
        chk("t2.count1", 64'(count), 64'd1);
        chk("t2.pc1", 64'(pc_d), 64'h200);
        push(32'h204, 32'h2);
        step();
        chk("t2.count2", 64'(count), 64'd2);
        chk("t2.ready_full", 64'(fetch_ready), 64'd0);
        push(32'h208, 32'h3);
        step();
        chk("t2.refused", 64'(count), 64'd2);
        chk("t2.pc_held", 64'(pc_d), 64'h200);
        chk("t2.instr_held", 64'(instruction_d), 64'h1);
        stall_d = 1'b0;  // pop 0x200; push of 0x208 still blocked (full)
        step();
        chk("t2.pc204", 64'(pc_d), 64'h204);
        chk("t2.count_after_pop", 64'(count), 64'd1);
        chk("t2.ready_again", 64'(fetch_ready), 64'd1);
        step();          // 0x208 accepted, 0x204 retired
        chk("t2.pc208", 64'(pc_d), 64'h208);
        chk("t2.instr208", 64'(instruction_d), 64'h3);
        chk("t2.count_pp", 64'(count), 64'd1);
        fetch_valid = 1'b0;
        step();
        chk_empty("t2.drain");

        // Test 3: streaming push/pop, no bubbles, count stays 1.
        for (int i = 0; i < 10; i++) begin
            push(32'(4 * i), 32'(32'hA000 + i));
            step();
            chk($sformatf("t3.pc%0d", i), 64'(pc_d), 64'(4 * i));
            chk($sformatf("t3.ins%0d", i), 64'(instruction_d), 64'(32'hA000 + i));
            chk($sformatf("t3.cnt%0d", i), 64'(count), 64'd1);
        end
        fetch_valid = 1'b0;
        step();
        chk_empty("t3.drain");

        // Test 4: full buffer, then flush + stall + push together.
        stall_d = 1'b1;
        push(32'h300, 32'h11);
        step();
        push(32'h304, 32'h12);
        step();
        chk("t4.full", 64'(count), 64'd2);
        flush = 1'b1;
        push(32'h308, 32'h13);
        step();
        chk_empty("t4.flush");
`ifdef FETCH_BUF_STATS_EN
        chk("t4.flushed_entries", 64'(flushed_entries), 64'd2);
`endif
        fetch_valid = 1'b0; stall_d = 1'b0;
        step();          // flush on an empty buffer
        chk_empty("t4.flush_empty");
        flush = 1'b0;
        push(32'h310, 32'h14);
        step();
        chk("t4.after_flush_pc", 64'(pc_d), 64'h310);
        chk("t4.after_flush_ins", 64'(instruction_d), 64'h14);

        // Test 5: asynchronous reset between edges with count=2.
        stall_d = 1'b1;
        push(32'h400, 32'h21);
        step();
        fetch_valid = 1'b0;
        chk("t5.full", 64'(count), 64'd2);
        #2 reset = 1'b0;
        #1;
        chk_empty("t5.async");
        chk("t5.pc", 64'(pc_d), 64'd0);
        chk("t5.pc4", 64'(pc_plus4_d), 64'd4);
        #1 reset = 1'b1;
        stall_d = 1'b0;
        step();
        chk_empty("t5.post");

        // Test 6: PC wrap for pc_plus4_d.
        push(32'hFFFF_FFFC, 32'h31);
        step();
        chk("t6.pc", 64'(pc_d), 64'hFFFF_FFFC);
        chk("t6.pc4", 64'(pc_plus4_d), 64'h0);
        fetch_valid = 1'b0;
        step();
        chk_empty("t6.drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
